// File: rtl/mic_buf_pkg.sv
// Shared types and constants for the microphone ping-pong buffer writer.
// Optional feature macro (used in mic_buffer_writer): MIC_BUF_DROP_CNT_EN.
package mic_buf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [31:0] WORD_BYTES = 32'd4;
   localparam logic [3:0]  WEN_ALL    = 4'hF;

   // First word index of the upper half of a 2^addr_w deep buffer.
   function automatic logic [31:0] half_first_idx(input int unsigned addr_w);
      return 32'd1 << (addr_w - 32'd1);
   endfunction

   // Last word index of the lower (upper=0) or upper (upper=1) half.
   function automatic logic [31:0] half_last_idx(input int unsigned addr_w, input logic upper);
      if (upper) begin
         return (32'd1 << addr_w) - 32'd1;
      end else begin
         return half_first_idx(addr_w) - 32'd1;
      end
   endfunction

endpackage

// File: rtl/mic_buf_half_flags.sv
// Per-half "done" flags with PS acknowledge, plus overrun detection.
// An ack is applied before the overrun check; a set in the same cycle as an ack wins.
module mic_buf_half_flags
   import mic_buf_pkg::*;
#(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              arm,
   input  logic              chk_valid,
   input  logic              write,
   input  logic [ADDR_W-1:0] word_index,
   input  logic [1:0]        half_ack,
   output logic              overrun_hit,
   output logic [1:0]        half_done,
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] LOWER_FIRST = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] UPPER_FIRST = ADDR_W'(half_first_idx(ADDR_W));
   localparam logic [ADDR_W-1:0] LOWER_LAST  = ADDR_W'(half_last_idx(ADDR_W, 1'b0));
   localparam logic [ADDR_W-1:0] UPPER_LAST  = ADDR_W'(half_last_idx(ADDR_W, 1'b1));

   logic [1:0] half_done_r;
   logic [1:0] pending_s;
   logic [1:0] set_s;
   logic       overrun_r;

   // Acked view of the flags, half-completion sets, and overrun detect.
   always_comb begin
      pending_s = half_done_r & ~half_ack;
      set_s     = 2'b00;
      if (write) begin
         set_s[0] = (word_index == LOWER_LAST);
         set_s[1] = (word_index == UPPER_LAST);
      end else begin
         set_s = 2'b00;
      end
      overrun_hit = chk_valid &
                    (((word_index == LOWER_FIRST) & pending_s[0]) |
                     ((word_index == UPPER_FIRST) & pending_s[1]));
   end

   // Flag registers: cleared on arm, otherwise ack-then-set, overrun sticky.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         half_done_r <= 2'b00;
         overrun_r   <= 1'b0;
      end else if (arm) begin
         half_done_r <= 2'b00;
         overrun_r   <= 1'b0;
      end else begin
         half_done_r <= pending_s | set_s;
         if (overrun_hit) begin
            overrun_r <= 1'b1;
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

   assign half_done = half_done_r;
   assign overrun   = overrun_r;

endmodule

// File: rtl/mic_buffer_writer.sv
// Writes NUM_MICS parallel words per strobe into a shared-address ping-pong
// BRAM buffer with one-cycle registered write port and overrun protection.
// Optional feature macro: MIC_BUF_DROP_CNT_EN (adds drop_count output).
module mic_buffer_writer
   import mic_buf_pkg::*;
#(
   parameter int NUM_MICS   = 8,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_W     = 14
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           enable,
   input  logic [NUM_MICS*DATA_WIDTH-1:0] mic_data,
   input  logic                           mic_data_valid,
   input  logic [1:0]                     half_ack,
   output logic [31:0]                    bram_addr,
   output logic [3:0]                     bram_wen,
   output logic [NUM_MICS*DATA_WIDTH-1:0] bram_din,
   output logic [1:0]                     half_done,
   output logic                           overrun,
   output logic                           busy
`ifdef MIC_BUF_DROP_CNT_EN
   ,output logic [15:0]                   drop_count
`endif
);

   state_t                         state_r;
   state_t                         state_s;
   logic [ADDR_W-1:0]              word_index_r;
   logic [31:0]                    addr_r;
   logic [3:0]                     wen_r;
   logic [NUM_MICS*DATA_WIDTH-1:0] din_r;
   logic                           arm_s;
   logic                           chk_valid_s;
   logic                           write_s;
   logic                           overrun_hit_s;

   // Qualify arming and the strobes that are eligible to be written.
   always_comb begin
      arm_s       = (state_r == IDLE) & enable;
      chk_valid_s = (state_r == RUN) & enable & mic_data_valid;
   end

   // A strobe is written unless it would overwrite an unacknowledged half.
   always_comb begin
      write_s = chk_valid_s & ~overrun_hit_s;
   end

   // Next-state logic: disable always returns to IDLE, overrun parks in HALT.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable) begin
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (!enable) begin
               state_s = IDLE;
            end else if (overrun_hit_s) begin
               state_s = HALT;
            end else begin
               state_s = RUN;
            end
         end
         HALT: begin
            if (!enable) begin
               state_s = IDLE;
            end else begin
               state_s = HALT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Word index and registered BRAM write port (one-cycle latency).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         word_index_r <= {ADDR_W{1'b0}};
         addr_r       <= 32'd0;
         wen_r        <= 4'h0;
         din_r        <= {(NUM_MICS*DATA_WIDTH){1'b0}};
      end else begin
         if (arm_s) begin
            word_index_r <= {ADDR_W{1'b0}};
         end else if (write_s) begin
            word_index_r <= word_index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
         end else begin
            word_index_r <= word_index_r;
         end
         if (write_s) begin
            wen_r  <= WEN_ALL;
            addr_r <= 32'(word_index_r) * WORD_BYTES;
            din_r  <= mic_data;
         end else begin
            wen_r  <= 4'h0;
            addr_r <= addr_r;
            din_r  <= din_r;
         end
      end
   end

   mic_buf_half_flags #(
      .ADDR_W (ADDR_W)
   ) u_half_flags (
      .clk         (clk),
      .rstn        (rstn),
      .arm         (arm_s),
      .chk_valid   (chk_valid_s),
      .write       (write_s),
      .word_index  (word_index_r),
      .half_ack    (half_ack),
      .overrun_hit (overrun_hit_s),
      .half_done   (half_done),
      .overrun     (overrun)
   );

`ifdef MIC_BUF_DROP_CNT_EN
   logic [15:0] drop_cnt_r;

   // Saturating count of strobes discarded while halted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         drop_cnt_r <= 16'd0;
      end else if (arm_s) begin
         drop_cnt_r <= 16'd0;
      end else if ((state_r == HALT) && mic_data_valid && (drop_cnt_r != 16'hFFFF)) begin
         drop_cnt_r <= drop_cnt_r + 16'd1;
      end else begin
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign drop_count = drop_cnt_r;
`endif

   assign bram_addr = addr_r;
   assign bram_wen  = wen_r;
   assign bram_din  = din_r;
   assign busy      = (state_r == RUN);

endmodule

// File: doc/mic_buffer_writer.md
Name: mic_buffer_writer

Overview:
- Sits directly downstream of the per-microphone PDM deserialisers (pdm_mic) and upstream of the PS-visible BRAM port-B interfaces.
- Takes the NUM_MICS parallel 32-bit words on each mic_data_valid and writes them into a circular ping-pong buffer, one BRAM per microphone, all sharing one address.
- Raises a per-half "done" flag that the PS acknowledges, and detects overrun when the PS falls behind.
- Replaces free-running address generation with flow-controlled, half-buffer-aware addressing.

Parameters:
- NUM_MICS, 8, number of microphone channels / BRAMs.
- DATA_WIDTH, 32, bits per microphone word.
- ADDR_W, 14, word-index width; buffer depth = 2^ADDR_W words per BRAM; must be >= 2.

Ports:
- clk  in  1  system clock (FCLK_CLK0 domain).
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  capture enable from PS trigger register; level-sensitive.
- mic_data  in  NUM_MICS*DATA_WIDTH  flattened words; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- mic_data_valid  in  1  single-cycle strobe: all channels' words are valid this cycle.
- half_ack  in  2  PS acknowledge pulses; bit0 clears lower half, bit1 clears upper half.
- bram_addr  out  32  byte address = word_index*4, zero-extended; shared by all BRAMs.
- bram_wen  out  4  byte write enables, 4'hF or 4'h0; shared.
- bram_din  out  NUM_MICS*DATA_WIDTH  registered copy of mic_data.
- half_done  out  2  sticky flags: bit0 lower half full, bit1 upper half full.
- overrun  out  1  sticky error flag.
- busy  out  1  high in RUN.

Behaviour:
- Reset (async, rstn=0): state IDLE; word_index=0; bram_addr=0; bram_wen=0; bram_din=0; half_done=0; overrun=0; busy=0.
- States:
  - IDLE: enable=1 -> RUN, word_index cleared to 0, half_done and overrun cleared.
  - RUN: enable=0 -> IDLE. Overrun detected -> HALT.
  - HALT: no writes. enable=0 -> IDLE. overrun stays set until the next IDLE->RUN arm.
- Write pipeline: in RUN, mic_data_valid at cycle N -> at N+1 bram_wen=4'hF, bram_addr=word_index*4, bram_din=mic_data sampled at N; word_index increments. bram_wen is 0 in every other cycle.
- Latency is exactly 1 cycle. Back-to-back valids, one per cycle, are supported with no bubbles.
- Wrap-around: word_index is ADDR_W bits and wraps from 2^ADDR_W-1 to 0.
- Half completion:
  - Writing index 2^(ADDR_W-1)-1 sets half_done[0] in the same cycle wen is asserted.
  - Writing index 2^ADDR_W-1 sets half_done[1] in the same cycle wen is asserted.
- Overrun:
  - A valid arriving when word_index is 0 and half_done[0]=1, or word_index is 2^(ADDR_W-1) and half_done[1]=1, is not written.
  - That cycle sets overrun=1 and the FSM enters HALT. The offending word is discarded.
- half_ack[k]=1 clears half_done[k] next cycle.
- Ack on the same cycle as that bit is set: set wins.
- Ack of a bit already 0 is ignored.
- Ack on the same cycle as the overrun check of that half: the ack is applied first, so no overrun.
- Valids in IDLE or HALT are dropped silently.
- enable falling on the same cycle as a valid: the valid is dropped; a write already registered from the prior cycle still completes.
- Reset mid-write: all outputs go to reset values immediately; no partial write is guaranteed.

Optional Feature:
- Macro: MIC_BUF_DROP_CNT_EN.
- Defined:
  - Adds output drop_count [15:0], a saturating count of valids dropped while in HALT.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on IDLE->RUN.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package mic_buf_pkg:
  - state enum {IDLE, RUN, HALT}.
  - WORD_BYTES=4 and WEN_ALL=4'hF.
  - Helper function for half-boundary index constants from ADDR_W.
- One sub-module, mic_buf_half_flags: holds half_done and overrun set/ack priority logic and drives the overrun detect to the FSM.
- Addressing, data registers and FSM stay in the top.

Test Plan (bench uses ADDR_W=4: 16 words, half = 8):
- Reset, enable=1, 8 valids with data 0x1000+k -> wen pulses at addrs 0x00..0x1C, din matches one cycle later; half_done=2'b01 coincident with the addr 0x1C write.
- Continue 8 more valids with half_ack[0] pulsed mid-way -> half_done=2'b10 after the addr 0x3C write; index wraps and the next write goes to addr 0x00.
- Fill both halves, no acks, 17th valid -> no wen, overrun=1, busy=0 (HALT); with MIC_BUF_DROP_CNT_EN, 3 further valids -> drop_count=3.
- half_ack[0] on the same cycle as the 17th valid -> write to addr 0x00 proceeds, overrun stays 0.
- 16 valids back-to-back at one per cycle -> 16 consecutive wen cycles, addresses strictly incrementing by 4, no bubbles.
- Assert rstn=0 between a valid and its write cycle -> wen=0 and all outputs 0 immediately; after release and enable, the first write is at addr 0.
